// File: rtl/mux_serializer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_pkg                                                              |
// | Shared state encoding and sizing constants for mux_serializer.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mux_pkg;

    localparam int SEL_W  = 4;
    localparam int NUM_IN = 16;

    localparam logic [SEL_W-1:0] LAST_SEL = 4'd15;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mux_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_serializer_if                                                    |
// | Load handshake and serial output bundle of mux_serializer.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface mux_serializer_if;

    logic                           load_valid;
    logic                           load_ready;
    logic [mux_pkg::NUM_IN-1:0]     data_in;
    logic                           abort;
    logic [mux_pkg::SEL_W-1:0]      sel;
    logic                           ser_out;
    logic                           ser_valid;
    logic                           done;

    modport master (
        output load_valid, data_in, abort,
        input  load_ready, sel, ser_out, ser_valid, done
    );

    modport slave (
        input  load_valid, data_in, abort,
        output load_ready, sel, ser_out, ser_valid, done
    );

endinterface
`default_nettype wire

// File: rtl/mux_serializer_mux16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_16                                                               |
// | 16:1 bit-select mux; s[0] is the most significant select bit.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mux_16 (
    input  wire logic       a,
    input  wire logic       b,
    input  wire logic       c,
    input  wire logic       d,
    input  wire logic       e,
    input  wire logic       f,
    input  wire logic       g,
    input  wire logic       h,
    input  wire logic       i,
    input  wire logic       j,
    input  wire logic       k,
    input  wire logic       l,
    input  wire logic       m,
    input  wire logic       n,
    input  wire logic       o,
    input  wire logic       p,
    input  wire logic [3:0] s,
    output logic            out
);

    logic [15:0] w_in;
    logic [3:0]  w_idx;

    assign w_in  = {p, o, n, m, l, k, j, i, h, g, f, e, d, c, b, a};
    assign w_idx = {s[0], s[1], s[2], s[3]};
    assign out   = w_in[w_idx];

endmodule
`default_nettype wire

// File: rtl/mux_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_serializer                                                       |
// | Steps the 16:1 mux select across a latched word, LSB first.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mux_serializer
    import mux_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int CNT_W        = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    mux_serializer_if.slave bus
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [NUM_IN-1:0] r_shadow;
    logic [SEL_W-1:0]  r_sel;
    logic [CNT_W-1:0]  r_cnt;

    logic w_accept;
    logic w_bit_end;
    logic w_last_bit;
    logic w_load_ready;
    logic w_ser_valid;
    logic w_done;
    logic w_mux_out;

    assign w_accept   = bus.load_valid & w_load_ready;
    assign w_bit_end  = (r_cnt == C_CNT_LAST);
    assign w_last_bit = w_bit_end & (r_sel == LAST_SEL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = SHIFT;
            SHIFT: begin
                if (bus.abort)       w_next = IDLE;
                else if (w_last_bit) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_load_ready = 1'b0;
        w_ser_valid  = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE:    w_load_ready = ~bus.abort;
            SHIFT:   w_ser_valid  = 1'b1;
            DONE:    w_done       = 1'b1;
            default: w_load_ready = 1'b0;
        endcase
    end

    // sel parks on LAST_SEL after a word and only restarts on the next accept or an abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_sel    <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shadow <= bus.data_in;
                        r_sel    <= '0;
                        r_cnt    <= '0;
                    end
                end
                SHIFT: begin
                    if (bus.abort) begin
                        r_sel <= '0;
                        r_cnt <= '0;
                    end else if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_sel != LAST_SEL) r_sel <= r_sel + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.abort) r_sel <= '0;
                end
                default: begin
                    r_sel <= '0;
                    r_cnt <= '0;
                end
            endcase
        end
    end

    mux_16 u_mux (
        .a   (r_shadow[0]),
        .b   (r_shadow[1]),
        .c   (r_shadow[2]),
        .d   (r_shadow[3]),
        .e   (r_shadow[4]),
        .f   (r_shadow[5]),
        .g   (r_shadow[6]),
        .h   (r_shadow[7]),
        .i   (r_shadow[8]),
        .j   (r_shadow[9]),
        .k   (r_shadow[10]),
        .l   (r_shadow[11]),
        .m   (r_shadow[12]),
        .n   (r_shadow[13]),
        .o   (r_shadow[14]),
        .p   (r_shadow[15]),
        .s   ({r_sel[0], r_sel[1], r_sel[2], r_sel[3]}),
        .out (w_mux_out)
    );

    assign bus.load_ready = w_load_ready;
    assign bus.sel        = r_sel;
    assign bus.ser_valid  = w_ser_valid;
    assign bus.ser_out    = w_mux_out & w_ser_valid;
    assign bus.done       = w_done;

endmodule
`default_nettype wire

// File: tb/tb_mux_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mux_serializer                                                    |
// | Scoreboard bench for mux_serializer at CLKS_PER_BIT = 1 and 3.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mux_serializer;
    import mux_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;
    logic q1[$];
    logic q3[$];

    mux_serializer_if bus1 ();
    mux_serializer_if bus3 ();

    mux_serializer #(.CLKS_PER_BIT(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    mux_serializer #(.CLKS_PER_BIT(3), .CNT_W(8)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        bus1.load_valid = 1'b0; bus1.abort = 1'b0; bus1.data_in = '0;
        bus3.load_valid = 1'b0; bus3.abort = 1'b0; bus3.data_in = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus1.load_ready !== 1'b1) begin n_mis++; $display("FAIL rst_load_ready got=%b required=1", bus1.load_ready); end
        n_cmp++; if (bus1.ser_valid !== 1'b0) begin n_mis++; $display("FAIL rst_ser_valid got=%b required=0", bus1.ser_valid); end
        n_cmp++; if (bus1.sel !== 4'd0) begin n_mis++; $display("FAIL rst_sel got=%0d required=0", bus1.sel); end
        n_cmp++; if (bus1.done !== 1'b0) begin n_mis++; $display("FAIL rst_done got=%b required=0", bus1.done); end
        n_cmp++; if (bus1.ser_out !== 1'b0) begin n_mis++; $display("FAIL rst_ser_out got=%b required=0", bus1.ser_out); end
        n_cmp++; if (bus3.load_ready !== 1'b1) begin n_mis++; $display("FAIL rst_load_ready3 got=%b required=1", bus3.load_ready); end
        rst = 1'b0;
        // start a word, then hit rst between edges while it shifts
        @(negedge clk);
        bus1.data_in = 16'hA5C3; bus1.load_valid = 1'b1;
        @(negedge clk);
        bus1.load_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (bus1.ser_valid !== 1'b1) begin n_mis++; $display("FAIL rst_midword_active got=%b required=1", bus1.ser_valid); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus1.ser_valid !== 1'b0) begin n_mis++; $display("FAIL rst_async_ser_valid got=%b required=0", bus1.ser_valid); end
        n_cmp++; if (bus1.sel !== 4'd0) begin n_mis++; $display("FAIL rst_async_sel got=%0d required=0", bus1.sel); end
        n_cmp++; if (bus1.load_ready !== 1'b1) begin n_mis++; $display("FAIL rst_async_load_ready got=%b required=1", bus1.load_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_word();
        logic exp_bits [16];
        logic e;
        exp_bits = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        bus1.data_in = 16'hA5C3; bus1.load_valid = 1'b1;
        for (int k = 0; k < 16; k++) q1.push_back(exp_bits[k]);
        n_cmp++; if (bus1.load_ready !== 1'b1) begin n_mis++; $display("FAIL basic_ready got=%b required=1", bus1.load_ready); end
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            bus1.load_valid = 1'b0;
            n_cmp++; if (bus1.ser_valid !== 1'b1) begin n_mis++; $display("FAIL basic_valid c%0d got=%b required=1", c, bus1.ser_valid); end
            n_cmp++; if (bus1.sel !== 4'(c - 1)) begin n_mis++; $display("FAIL basic_sel c%0d got=%0d required=%0d", c, bus1.sel, c - 1); end
            n_cmp++;
            if (q1.size() == 0) begin n_mis++; $display("FAIL basic_bit c%0d got=%b required=none_queued", c, bus1.ser_out); end
            else begin
                e = q1.pop_front();
                if (bus1.ser_out !== e) begin n_mis++; $display("FAIL basic_bit c%0d got=%b required=%b", c, bus1.ser_out, e); end
            end
        end
        @(negedge clk);
        n_cmp++; if (bus1.done !== 1'b1) begin n_mis++; $display("FAIL basic_done got=%b required=1", bus1.done); end
        n_cmp++; if (bus1.ser_valid !== 1'b0 || bus1.ser_out !== 1'b0) begin n_mis++; $display("FAIL basic_done_quiet got=%b%b required=00", bus1.ser_valid, bus1.ser_out); end
        n_cmp++; if (bus1.sel !== 4'd15) begin n_mis++; $display("FAIL basic_done_sel got=%0d required=15", bus1.sel); end
        @(negedge clk);
        n_cmp++; if (bus1.done !== 1'b0) begin n_mis++; $display("FAIL basic_done_pulse got=%b required=0", bus1.done); end
        n_cmp++; if (bus1.load_ready !== 1'b1) begin n_mis++; $display("FAIL basic_idle_ready got=%b required=1", bus1.load_ready); end
        n_cmp++; if (bus1.sel !== 4'd15) begin n_mis++; $display("FAIL basic_idle_sel got=%0d required=15", bus1.sel); end
    endtask

    task automatic test_bit_period();
        logic [15:0] w;
        logic        e;
        int          ones;
        int          dones;
        w = 16'h0001;
        ones = 0;
        dones = 0;
        @(negedge clk);
        bus3.data_in = w; bus3.load_valid = 1'b1;
        for (int k = 0; k < 16; k++) for (int r = 0; r < 3; r++) q3.push_back(w[k]);
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            bus3.load_valid = 1'b0;
            bus3.data_in = 16'hFFFF;
            if (bus3.ser_out === 1'b1) ones++;
            n_cmp++; if (bus3.ser_valid !== 1'b1) begin n_mis++; $display("FAIL period_valid c%0d got=%b required=1", c, bus3.ser_valid); end
            n_cmp++; if (bus3.sel !== 4'(c / 3)) begin n_mis++; $display("FAIL period_sel c%0d got=%0d required=%0d", c, bus3.sel, c / 3); end
            n_cmp++;
            if (q3.size() == 0) begin n_mis++; $display("FAIL period_bit c%0d got=%b required=none_queued", c, bus3.ser_out); end
            else begin
                e = q3.pop_front();
                if (bus3.ser_out !== e) begin n_mis++; $display("FAIL period_bit c%0d got=%b required=%b", c, bus3.ser_out, e); end
            end
        end
        n_cmp++; if (ones != 3) begin n_mis++; $display("FAIL period_ones got=%0d required=3", ones); end
        @(negedge clk);
        n_cmp++; if (bus3.done !== 1'b1) begin n_mis++; $display("FAIL period_done got=%b required=1", bus3.done); end
        for (int c = 0; c < 6; c++) begin
            if (bus3.done === 1'b1) dones++;
            @(negedge clk);
        end
        n_cmp++; if (dones != 1) begin n_mis++; $display("FAIL period_done_count got=%0d required=1", dones); end
    endtask

    task automatic test_back_to_back();
        int   first[$];
        logic prev_sv;
        int   dones;
        int   done_cyc;
        logic e;
        prev_sv = 1'b0;
        dones = 0;
        done_cyc = -1;
        @(negedge clk);
        bus1.data_in = 16'hFFFF; bus1.load_valid = 1'b1;
        for (int k = 0; k < 16; k++) q1.push_back(1'b1);
        for (int k = 0; k < 16; k++) q1.push_back(1'b0);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (c == 0) bus1.data_in = 16'h0000;
            if (bus1.ser_valid === 1'b1 && prev_sv === 1'b0) first.push_back(c);
            prev_sv = bus1.ser_valid;
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                n_cmp++; if (bus1.load_ready !== 1'b1) begin n_mis++; $display("FAIL b2b_ready_after_done got=%b required=1", bus1.load_ready); end
            end
            if (bus1.done === 1'b1) begin
                dones++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (bus1.ser_valid === 1'b1) begin
                n_cmp++;
                if (q1.size() == 0) begin n_mis++; $display("FAIL b2b_bit c%0d got=%b required=none_queued", c, bus1.ser_out); end
                else begin
                    e = q1.pop_front();
                    if (bus1.ser_out !== e) begin n_mis++; $display("FAIL b2b_bit c%0d got=%b required=%b", c, bus1.ser_out, e); end
                end
            end
            if (first.size() >= 2) bus1.load_valid = 1'b0;
        end
        bus1.load_valid = 1'b0;
        n_cmp++;
        if (first.size() != 2) begin n_mis++; $display("FAIL b2b_words got=%0d required=2", first.size()); end
        else if (first[1] - first[0] != 18) begin n_mis++; $display("FAIL b2b_spacing got=%0d required=18", first[1] - first[0]); end
        n_cmp++; if (done_cyc != 16) begin n_mis++; $display("FAIL b2b_done_cycle got=%0d required=16", done_cyc); end
        n_cmp++; if (dones != 2) begin n_mis++; $display("FAIL b2b_done_count got=%0d required=2", dones); end
        n_cmp++; if (q1.size() != 0) begin n_mis++; $display("FAIL b2b_leftover got=%0d required=0", q1.size()); end
        q1.delete();
    endtask

    task automatic test_abort();
        logic found;
        logic e;
        int   dones;
        logic [15:0] w;
        w = 16'h3C5A;
        found = 1'b0;
        dones = 0;
        @(negedge clk);
        bus1.data_in = w; bus1.load_valid = 1'b1;
        for (int k = 0; k < 16; k++) q1.push_back(w[k]);
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            bus1.load_valid = 1'b0;
            n_cmp++;
            if (q1.size() == 0) begin n_mis++; $display("FAIL abort_bit c%0d got=%b required=none_queued", c, bus1.ser_out); end
            else begin
                e = q1.pop_front();
                if (bus1.ser_out !== e) begin n_mis++; $display("FAIL abort_bit c%0d got=%b required=%b", c, bus1.ser_out, e); end
            end
            if (bus1.sel === 4'd7) found = 1'b1;
        end
        n_cmp++; if (found !== 1'b1) begin n_mis++; $display("FAIL abort_reach_sel7 got=0 required=1"); end
        bus1.abort = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus1.ser_valid !== 1'b0) begin n_mis++; $display("FAIL abort_ser_valid got=%b required=0", bus1.ser_valid); end
        n_cmp++; if (bus1.sel !== 4'd0) begin n_mis++; $display("FAIL abort_sel got=%0d required=0", bus1.sel); end
        n_cmp++; if (bus1.load_ready !== 1'b0) begin n_mis++; $display("FAIL abort_idle_blocked got=%b required=0", bus1.load_ready); end
        bus1.abort = 1'b0;
        #1;
        n_cmp++; if (bus1.load_ready !== 1'b1) begin n_mis++; $display("FAIL abort_idle_ready got=%b required=1", bus1.load_ready); end
        q1.delete();
        for (int c = 0; c < 20; c++) begin
            if (bus1.done === 1'b1) dones++;
            @(negedge clk);
        end
        n_cmp++; if (dones != 0) begin n_mis++; $display("FAIL abort_no_done got=%0d required=0", dones); end

        // abort coinciding with the final bit edge
        bus1.data_in = 16'h8001; bus1.load_valid = 1'b1;
        @(negedge clk);
        bus1.load_valid = 1'b0;
        repeat (15) @(negedge clk);
        n_cmp++; if (bus1.sel !== 4'd15 || bus1.ser_out !== 1'b1) begin n_mis++; $display("FAIL abort_last_pos got=%0d/%b required=15/1", bus1.sel, bus1.ser_out); end
        bus1.abort = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus1.done !== 1'b0 || bus1.ser_valid !== 1'b0) begin n_mis++; $display("FAIL abort_last_done got=%b%b required=00", bus1.done, bus1.ser_valid); end
        n_cmp++; if (bus1.sel !== 4'd0) begin n_mis++; $display("FAIL abort_last_sel got=%0d required=0", bus1.sel); end

        // abort in IDLE only blocks the offered word
        bus1.load_valid = 1'b1;
        #1;
        n_cmp++; if (bus1.load_ready !== 1'b0) begin n_mis++; $display("FAIL abort_idle_block got=%b required=0", bus1.load_ready); end
        @(negedge clk);
        bus1.abort = 1'b0; bus1.load_valid = 1'b0;
        n_cmp++; if (bus1.ser_valid !== 1'b0 || bus1.done !== 1'b0) begin n_mis++; $display("FAIL abort_idle_noaccept got=%b%b required=00", bus1.ser_valid, bus1.done); end
    endtask

    task automatic test_ignore_busy();
        logic [15:0] w;
        logic        e;
        w = 16'hA5C3;
        @(negedge clk);
        bus1.data_in = w; bus1.load_valid = 1'b1;
        for (int k = 0; k < 16; k++) q1.push_back(w[k]);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            bus1.load_valid = 1'b0;
            bus1.data_in = 16'($urandom);
            n_cmp++;
            if (q1.size() == 0) begin n_mis++; $display("FAIL busy_bit c%0d got=%b required=none_queued", c, bus1.ser_out); end
            else begin
                e = q1.pop_front();
                if (bus1.ser_out !== e) begin n_mis++; $display("FAIL busy_bit c%0d got=%b required=%b", c, bus1.ser_out, e); end
            end
            if (c == 5) begin
                bus1.data_in = 16'h1234; bus1.load_valid = 1'b1;
                #1;
                n_cmp++; if (bus1.load_ready !== 1'b0) begin n_mis++; $display("FAIL busy_ready got=%b required=0", bus1.load_ready); end
            end
        end
        @(negedge clk);
        n_cmp++; if (bus1.done !== 1'b1) begin n_mis++; $display("FAIL busy_done got=%b required=1", bus1.done); end
        @(negedge clk);
        n_cmp++; if (bus1.ser_valid !== 1'b0) begin n_mis++; $display("FAIL busy_no_reaccept got=%b required=0", bus1.ser_valid); end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        test_reset();
        test_basic_word();
        test_bit_period();
        test_back_to_back();
        test_abort();
        test_ignore_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
